fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter XLEN, default 32, address width.
REQ-002 SHALL provide parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL provide parameter EPOCH_W, default 2, redirect-epoch tag width.
REQ-004 SHALL provide parameter MAX_OUT, default 2, maximum outstanding instruction-memory requests.
REQ-005 CLK  in  1  clock; one clock domain, all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 mispredict  in  1  backend redirect strobe; actual_target_address  in  XLEN  redirect target.
REQ-008 pred_taken1, pred_taken2  in  1  per-slot predicted-taken for the packet accepted this cycle; final_pred_target1/2  in  XLEN  slot targets.
REQ-009 stall  in  1  fetch queue full; blocks new requests.
REQ-010 imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  XLEN  packet address.
REQ-011 imem_rsp_valid  in  1  in-order response for the oldest outstanding request.
REQ-012 fetch_valid  out  1  response accepted for decode; fetch_pc  out  XLEN  packet address of that response.
REQ-013 epoch  out  EPOCH_W  current redirect epoch.

Function
REQ-014 SHALL implement FSM: BOOT (after reset), RUN, FLUSH.
REQ-015 BOOT SHALL last exactly one cycle with imem_req_valid=0, then go to RUN.
REQ-016 imem_req_valid SHALL be 1 only in RUN, with stall=0 and outstanding count < MAX_OUT.
REQ-017 accept SHALL be imem_req_valid && imem_req_ready; imem_req_addr SHALL equal pc register.
REQ-018 Next pc priority SHALL be: mispredict -> actual_target_address; else accept&&pred_taken1 -> final_pred_target1; else accept&&pred_taken2 -> final_pred_target2; else accept -> pc+8; else hold.
REQ-019 pc+8 SHALL wrap modulo 2^XLEN.
REQ-020 mispredict SHALL act in any state, increment epoch (wrap modulo 2^EPOCH_W), and enter FLUSH.
REQ-021 FLUSH SHALL last one cycle with imem_req_valid=0, then RUN; mispredict during FLUSH SHALL restart FLUSH and increment epoch again.
REQ-022 Each accept SHALL push {pc, epoch} into a MAX_OUT-deep tag FIFO; each imem_rsp_valid SHALL pop the head.
REQ-023 fetch_valid SHALL be imem_rsp_valid && head epoch == current epoch; fetch_pc SHALL be head pc; mismatching responses SHALL be dropped silently.
REQ-024 Request accepted in the same cycle as mispredict SHALL be tagged with the old epoch and dropped on return.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged; pop on empty FIFO SHALL be ignored.

Reset
REQ-026 On reset assertion: pc=RESET_PC, epoch=0, FIFO empty, state=BOOT, imem_req_valid=0, fetch_valid=0, fetch_pc=0.
REQ-027 Reset mid-transaction SHALL discard all outstanding tags; responses arriving later SHALL be ignored.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs redirect_cnt (32) and drop_cnt (32), counting mispredicts and dropped responses, wrap at 2^32, reset to 0.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the FSM state enum, the tag struct {pc, epoch}, and constant FETCH_BYTES=8.
REQ-031 Tag FIFO SHALL be sub-module fetch_tag_fifo (parameterised depth and width).

Verification
REQ-032 Reset release, ready=1, no predictions -> no request in BOOT cycle, then addresses 0x0, 0x8, 0x10 on consecutive cycles.
REQ-033 Accept at 0x10 with pred_taken1=1, final_pred_target1=0x200 (slot2 also taken, 0x300) -> next address 0x200.
REQ-034 Two requests outstanding, ready=1 -> imem_req_valid=0 until one response returns.
REQ-035 Mispredict to 0x400 with two requests outstanding -> epoch 0->1, one FLUSH cycle, both responses dropped (fetch_valid=0), next request 0x400.
REQ-036 Mispredict coincident with accept at 0x20 -> 0x20 response dropped; next request at actual_target_address.
REQ-037 Four mispredicts with EPOCH_W=2 -> epoch wraps 3->0; with FETCH_PERF_CNT_EN, redirect_cnt=4.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer slice.
//   FETCH_BYTES  - byte stride of one fetch packet (two 4-byte slots)
//   fetch_state_e - sequencer FSM states
//   fetch_tag_t   - {pc, epoch} tag remembered for every outstanding request.
//                   Fields are sized for the widest supported configuration
//                   (XLEN <= 64, EPOCH_W <= 8); users zero-extend into it.
package fetch_pkg;

  localparam int FETCH_BYTES = 8;
  localparam int TAG_PC_W    = 64;
  localparam int TAG_EPOCH_W = 8;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [TAG_PC_W-1:0]    pc;
    logic [TAG_EPOCH_W-1:0] epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/response handshake.
//   imem_req_valid  - sequencer presents a packet request
//   imem_req_ready  - memory accepts the request this cycle
//   imem_req_addr   - packet address (XLEN)
//   imem_rsp_valid  - in-order response for the oldest outstanding request
// Modports: master = sequencer side, slave = memory side.
interface fetch_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid
  );
endinterface

// File: rtl/fetch_tag_fifo.sv
// fetch_tag_fifo: small in-order FIFO holding one tag per outstanding request.
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata - enqueue; ignored when full and not popping
//   pop        - dequeue head; ignored when empty
//   rdata      - head entry (undefined when empty)
//   count      - number of valid entries; empty - count == 0
module fetch_tag_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 34,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: generates instruction-memory packet requests, follows
// branch predictions and backend redirects, and filters stale responses by
// redirect epoch.
// Ports:
//   CLK, reset                  - clock, asynchronous active-low reset
//   mispredict, actual_target_address - backend redirect
//   pred_taken1/2, final_pred_target1/2 - per-slot prediction for the packet
//                                 accepted this cycle
//   stall                       - fetch queue full, blocks new requests
//   imem (fetch_sequencer_if.master) - instruction memory handshake
//   fetch_valid, fetch_pc       - response accepted for decode and its address
//   epoch                       - current redirect epoch
// Optional: define FETCH_PERF_CNT_EN to add redirect_cnt / drop_cnt counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              EPOCH_W  = 2,
  parameter int              MAX_OUT  = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   mispredict,
  input  logic [XLEN-1:0]        actual_target_address,
  input  logic                   pred_taken1,
  input  logic                   pred_taken2,
  input  logic [XLEN-1:0]        final_pred_target1,
  input  logic [XLEN-1:0]        final_pred_target2,
  input  logic                   stall,
  fetch_sequencer_if.master      imem,
  output logic                   fetch_valid,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [EPOCH_W-1:0]     epoch
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            redirect_cnt,
  output logic [31:0]            drop_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = XLEN + EPOCH_W;

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_next;
  logic             req_valid;
  logic             accept;
  logic [CNT_W-1:0] out_cnt;
  logic             fifo_empty;
  logic [TAG_W-1:0] head_data;
  fetch_tag_t       head;
  logic             epoch_match;
  logic             drop;

  assign req_valid           = (state == RUN) && !stall && (out_cnt < CNT_W'(MAX_OUT));
  assign accept              = req_valid && imem.imem_req_ready;
  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc;

  // Tag uses the epoch register before any same-cycle redirect bumps it, so a
  // packet accepted alongside a mispredict is recognised as stale on return.
  fetch_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (CLK),
    .rst_n (reset),
    .push  (accept),
    .wdata ({pc, epoch}),
    .pop   (imem.imem_rsp_valid),
    .rdata (head_data),
    .count (out_cnt),
    .empty (fifo_empty)
  );

  assign head = '{pc:    TAG_PC_W'(head_data[TAG_W-1:EPOCH_W]),
                  epoch: TAG_EPOCH_W'(head_data[EPOCH_W-1:0])};

  // Responses with no matching tag (e.g. after reset) are ignored entirely.
  assign epoch_match = (head.epoch == TAG_EPOCH_W'(epoch));
  assign fetch_valid = imem.imem_rsp_valid && !fifo_empty && epoch_match;
  assign drop        = imem.imem_rsp_valid && !fifo_empty && !epoch_match;
  assign fetch_pc    = fifo_empty ? '0 : XLEN'(head.pc);

  always_comb begin
    pc_next = pc;
    if (mispredict)                 pc_next = actual_target_address;
    else if (accept && pred_taken1) pc_next = final_pred_target1;
    else if (accept && pred_taken2) pc_next = final_pred_target2;
    else if (accept)                pc_next = pc + XLEN'(FETCH_BYTES);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      epoch <= '0;
    end else begin
      pc <= pc_next;
      if (mispredict) begin
        epoch <= epoch + EPOCH_W'(1);
        state <= FLUSH;
      end else begin
        // BOOT and FLUSH are single-cycle bubbles; RUN holds.
        state <= RUN;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      redirect_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (mispredict) redirect_cnt <= redirect_cnt + 32'd1;
      if (drop)       drop_cnt     <= drop_cnt + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        CLK;
  logic        reset;
  logic        mispredict;
  logic [31:0] actual_target_address;
  logic        pred_taken1;
  logic        pred_taken2;
  logic [31:0] final_pred_target1;
  logic [31:0] final_pred_target2;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  epoch;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fetch_sequencer_if #(.XLEN(32)) bus ();

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .EPOCH_W  (2),
    .MAX_OUT  (2)
  ) dut (
    .CLK                   (CLK),
    .reset                 (reset),
    .mispredict            (mispredict),
    .actual_target_address (actual_target_address),
    .pred_taken1           (pred_taken1),
    .pred_taken2           (pred_taken2),
    .final_pred_target1    (final_pred_target1),
    .final_pred_target2    (final_pred_target2),
    .stall                 (stall),
    .imem                  (bus),
    .fetch_valid           (fetch_valid),
    .fetch_pc              (fetch_pc),
    .epoch                 (epoch)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt          (redirect_cnt),
    .drop_cnt              (drop_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to the next falling edge and return inputs to idle defaults.
  task automatic step();
    @(negedge CLK);
    mispredict            = 1'b0;
    actual_target_address = '0;
    pred_taken1           = 1'b0;
    pred_taken2           = 1'b0;
    final_pred_target1    = '0;
    final_pred_target2    = '0;
    stall                 = 1'b0;
    bus.imem_req_ready    = 1'b1;
    bus.imem_rsp_valid    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", bus.imem_req_valid); end
    n_chk++; if (bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 00000000", bus.imem_req_addr); end
    n_chk++; if (epoch !== 2'd0) begin n_fail++; $display("FAIL rst_epoch got %0d want 0", epoch); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); end
    n_chk++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_pc got %h want 00000000", fetch_pc); end
`ifdef FETCH_PERF_CNT_EN
    n_chk++; if (redirect_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_redirect_cnt got %0d want 0", redirect_cnt); end
    n_chk++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_boot_sequence();
    step(); reset = 1'b1; #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_req_valid got %b want 0", bus.imem_req_valid); end
    step(); #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL seq_addr0 got %b/%h want 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL seq_addr8 got %b/%h want 1/00000008", bus.imem_req_valid, bus.imem_req_addr); end
    n_chk++; if ({fetch_valid, fetch_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rsp0 got %b/%h want 1/00000000", fetch_valid, fetch_pc); end
  endtask

  task automatic test_pred_taken();
    step();
    pred_taken1 = 1'b1; final_pred_target1 = 32'h200;
    pred_taken2 = 1'b1; final_pred_target2 = 32'h300;
    #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL seq_addr10 got %b/%h want 1/00000010", bus.imem_req_valid, bus.imem_req_addr); end
    step(); #1;
    n_chk++; if (bus.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL pred_target got %h want 00000200", bus.imem_req_addr); end
  endtask

  task automatic test_max_outstanding();
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_a got %b want 0", bus.imem_req_valid); end
    step(); #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_b got %b want 0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if ({fetch_valid, fetch_pc} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL rsp8 got %b/%h want 1/00000008", fetch_valid, fetch_pc); end
    step(); #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL reopen got %b/%h want 1/00000200", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_mispredict_flush();
    step(); mispredict = 1'b1; actual_target_address = 32'h400; #1;
    n_chk++; if (epoch !== 2'd0) begin n_fail++; $display("FAIL pre_mp_epoch got %0d want 0", epoch); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if (epoch !== 2'd1) begin n_fail++; $display("FAIL mp_epoch got %0d want 1", epoch); end
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drop_a got %b want 0", fetch_valid); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drop_b got %b want 0", fetch_valid); end
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL redirect_addr got %b/%h want 1/00000400", bus.imem_req_valid, bus.imem_req_addr); end
    step(); stall = 1'b1; bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid got %b want 0", bus.imem_req_valid); end
    n_chk++; if ({fetch_valid, fetch_pc} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL rsp400 got %b/%h want 1/00000400", fetch_valid, fetch_pc); end
  endtask

  task automatic test_mispredict_with_accept();
    step(); bus.imem_req_ready = 1'b0; mispredict = 1'b1; actual_target_address = 32'h20; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h408}) begin n_fail++; $display("FAIL seq_addr408 got %b/%h want 1/00000408", bus.imem_req_valid, bus.imem_req_addr); end
    step(); #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.imem_req_valid); end
    n_chk++; if (epoch !== 2'd2) begin n_fail++; $display("FAIL epoch2 got %0d want 2", epoch); end
    step(); mispredict = 1'b1; actual_target_address = 32'h600; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL addr20 got %b/%h want 1/00000020", bus.imem_req_valid, bus.imem_req_addr); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drop20 got %b want 0", fetch_valid); end
    n_chk++; if (epoch !== 2'd3) begin n_fail++; $display("FAIL epoch3 got %0d want 3", epoch); end
    step(); bus.imem_req_ready = 1'b0; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h600}) begin n_fail++; $display("FAIL addr600 got %b/%h want 1/00000600", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_epoch_wrap();
    step(); bus.imem_req_ready = 1'b0; mispredict = 1'b1; actual_target_address = 32'h700;
    step(); bus.imem_req_ready = 1'b0; mispredict = 1'b1; actual_target_address = 32'h800; #1;
    n_chk++; if (epoch !== 2'd0) begin n_fail++; $display("FAIL epoch_wrap got %0d want 0", epoch); end
`ifdef FETCH_PERF_CNT_EN
    n_chk++; if (redirect_cnt !== 32'd4) begin n_fail++; $display("FAIL redirect_cnt got %0d want 4", redirect_cnt); end
    n_chk++; if (drop_cnt !== 32'd3) begin n_fail++; $display("FAIL drop_cnt got %0d want 3", drop_cnt); end
`endif
    step(); #1;
    n_chk++; if ({epoch, bus.imem_req_valid} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL flush_restart got %0d/%b want 1/0", epoch, bus.imem_req_valid); end
    step(); #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL addr800 got %b/%h want 1/00000800", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_pc_wrap();
    step(); bus.imem_req_ready = 1'b0; mispredict = 1'b1; actual_target_address = 32'hFFFF_FFF8;
    step();
    step(); #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'hFFFF_FFF8}) begin n_fail++; $display("FAIL addr_top got %b/%h want 1/fffffff8", bus.imem_req_valid, bus.imem_req_addr); end
    step(); #1;
    n_chk++; if (bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got %h want 00000000", bus.imem_req_addr); end
  endtask

  task automatic test_reset_mid_transaction();
    reset = 1'b0; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr, epoch} !== {1'b0, 32'h0, 2'd0}) begin n_fail++; $display("FAIL mid_rst got %b/%h/%0d want 0/00000000/0", bus.imem_req_valid, bus.imem_req_addr, epoch); end
`ifdef FETCH_PERF_CNT_EN
    n_chk++; if (redirect_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", redirect_cnt); end
`endif
    step(); reset = 1'b1; bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if ({bus.imem_req_valid, fetch_valid} !== 2'b00) begin n_fail++; $display("FAIL late_rsp_boot got %b/%b want 0/0", bus.imem_req_valid, fetch_valid); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if ({bus.imem_req_valid, bus.imem_req_addr, fetch_valid} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL late_rsp_run got %b/%h/%b want 1/00000000/0", bus.imem_req_valid, bus.imem_req_addr, fetch_valid); end
    step(); bus.imem_rsp_valid = 1'b1; #1;
    n_chk++; if ({fetch_valid, fetch_pc, bus.imem_req_addr} !== {1'b1, 32'h0, 32'h8}) begin n_fail++; $display("FAIL post_rst_rsp got %b/%h/%h want 1/00000000/00000008", fetch_valid, fetch_pc, bus.imem_req_addr); end
  endtask

  initial begin
    mispredict = 1'b0; actual_target_address = '0;
    pred_taken1 = 1'b0; pred_taken2 = 1'b0;
    final_pred_target1 = '0; final_pred_target2 = '0;
    stall = 1'b0; bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0;
    reset = 1'b0;
    test_reset();
    test_boot_sequence();
    test_pred_taken();
    test_max_outstanding();
    test_mispredict_flush();
    test_mispredict_with_accept();
    test_epoch_wrap();
    test_pc_wrap();
    test_reset_mid_transaction();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
